// File: rtl/rd_fwft_stage.sv
`timescale 1ns/1ps
// rd_fwft_stage
// Read-domain output stage of an asynchronous FIFO. It turns the memory's
// registered-read, empty/enable interface into a first-word-fall-through
// valid/ready stream using a 3-entry skid buffer. It also reports a registered
// fill level and an almost-empty flag derived from the synchronized Gray write
// pointer. Everything runs in rclk.
module rd_fwft_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic [PTR_WIDTH:0]    g_wptr_sync,
  input  logic [PTR_WIDTH:0]    b_rptr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [PTR_WIDTH:0]    rd_level,
  output logic                  almost_empty
);

  localparam int                 DEPTH    = 3;
  localparam int                 LW       = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] AE_LEVEL = LW'(AE_THRESH);

  // Skid buffer storage and bookkeeping.
  logic [DATA_WIDTH-1:0] entry [DEPTH];
  logic [1:0]            count;
  logic [1:0]            wr_idx;
  logic [1:0]            rd_idx;
  logic                  inflight;
  logic                  push;
  logic                  pop;
  logic [2:0]            credit_used;

  // Level computation.
  logic [PTR_WIDTH:0]    wbin;
  logic [PTR_WIDTH:0]    level_next;
  logic                  ae_next;

  // Indices run 0,1,2,0,... so the buffer depth does not have to be a power of 2.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // A read is only issued when a slot is guaranteed for its data, counting
  // the word already in flight. m_ready is deliberately not part of this, so
  // the read enable never depends combinationally on the downstream.
  assign credit_used = {1'b0, count} + {2'b00, inflight};
  assign fifo_rd_en  = !fifo_empty && (credit_used < 3'd3);

  // Data returned from the memory is written the cycle after the read enable.
  assign push    = inflight;
  assign m_valid = (count != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = entry[rd_idx];

  // Occupancy, indices and the in-flight marker.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      count    <= 2'd0;
      wr_idx   <= 2'd0;
      rd_idx   <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (push) wr_idx <= next_idx(wr_idx);
      if (pop)  rd_idx <= next_idx(rd_idx);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Capture returning read data into the slot at wr_idx.
  // NOTE: the buffer is only three words, so it is reset; this keeps m_data
  // at zero after reset and guarantees no stale word survives a reset.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else if (push) begin
      entry[wr_idx] <= fifo_rdata;
    end
  end

  // Gray-to-binary of the synchronized write pointer: bit i is the XOR of
  // all Gray bits from i up to the MSB.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < LW; i++) wbin[i] = ^(g_wptr_sync >> i);
  end

  // Words left in memory, modulo the pointer range; buffered and in-flight
  // words have already advanced b_rptr and so are excluded.
  assign level_next = wbin - b_rptr;
  assign ae_next    = (level_next <= AE_LEVEL);

  // Register the level and the almost-empty flag from the same next value.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_level     <= '0;
      almost_empty <= 1'b1;
    end else begin
      rd_level     <= level_next;
      almost_empty <= ae_next;
    end
  end

  // The credit rule makes a push into a full buffer impossible.
  a_no_push_when_full: assert property (
    @(posedge rclk) disable iff (!rrst_n) inflight |-> (count != 2'd3)
  );

endmodule

// File: doc/rd_fwft_stage.md
Name: rd_fwft_stage

Overview:
- Read-domain output stage placed directly downstream of the read-pointer/empty logic and the FIFO memory read port.
- Converts the FIFO's registered-read, empty/enable interface into a first-word-fall-through valid/ready stream using a 3-entry skid buffer.
- Also reports a registered read-side fill level and an almost-empty flag derived from the synchronized Gray write pointer.
- Runs entirely in rclk; it has no cross-domain logic of its own.

Parameters:
- DATA_WIDTH, 8, width of FIFO data words.
- PTR_WIDTH, 3, FIFO address width. Pointers are PTR_WIDTH+1 bits, and FIFO depth is 2^PTR_WIDTH.
- AE_THRESH, 1, almost_empty asserts when rd_level <= AE_THRESH.

Ports:
- rclk  in  1  read clock.
- rrst_n  in  1  reset, asynchronous, active-low.
- fifo_empty  in  1  registered empty flag from the read-pointer handler.
- fifo_rd_en  out  1  read enable to the read-pointer handler and memory.
- fifo_rdata  in  DATA_WIDTH  memory read data, valid the cycle after fifo_rd_en.
- g_wptr_sync  in  PTR_WIDTH+1  synchronized Gray write pointer.
- b_rptr  in  PTR_WIDTH+1  binary read pointer.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  DATA_WIDTH  output word (head of buffer).
- rd_level  out  PTR_WIDTH+1  words in FIFO memory not yet read.
- almost_empty  out  1  rd_level <= AE_THRESH.

Behaviour:
- Reset (async, rrst_n=0) clears the following:
  - buffer count=0, wr_idx=0, rd_idx=0, inflight=0.
  - m_valid=0, m_data=0, rd_level=0, almost_empty=1.
  - A reset mid-operation discards all buffered and in-flight words. m_valid drops immediately, without waiting for a clock edge.
- State consists of:
  - 3-entry register array.
  - count in 0..3, 2 bits.
  - wr_idx and rd_idx in 0..2; each wraps 2->0. No power-of-2 wrap is permitted.
  - inflight flag, 1 bit.
- fifo_rd_en is combinational: fifo_rd_en = !fifo_empty && (count + inflight < 3).
  - It must have no combinational dependence on m_ready.
  - It must never assert while fifo_empty=1.
- Read latency:
  - fifo_rd_en=1 in cycle t sets inflight=1 for cycle t+1.
  - fifo_rdata is sampled at the end of t+1 and written at wr_idx. The word is visible on m_data/m_valid in cycle t+2.
  - fifo_rdata is ignored whenever inflight=0.
- m_valid = (count != 0). m_data = entry[rd_idx].
- Pop occurs when m_valid && m_ready. The pop advances rd_idx.
- Push and pop in the same cycle leave count unchanged; both indices advance.
- A push while count=3 cannot occur because of the credit rule. Flag it with an assertion.
- Ordering: words leave in exactly the order they were read, with no loss and no duplication.
- Throughput: with m_ready held at 1 and the FIFO non-empty, one word per cycle in steady state after the 2-cycle fill latency.
- m_data must stay stable while m_valid=1 && m_ready=0.
- Level:
  - Convert g_wptr_sync from Gray to binary (prefix XOR from MSB).
  - rd_level <= (wbin - b_rptr), modulo 2^(PTR_WIDTH+1), registered one cycle. Valid range is 0..2^PTR_WIDTH.
  - almost_empty is registered from the same next-level value in the same cycle.
  - rd_level excludes words already in the skid buffer or in flight.

Test Plan:
1. Reset with fifo_empty=1 -> m_valid=0, fifo_rd_en=0, rd_level=0, almost_empty=1; no rd_en for 10 cycles.
2. FIFO holds 0x10..0x17, fifo_empty falls at cycle 0, m_ready=1 -> fifo_rd_en from cycle 0; m_valid from cycle 2; m_data 0x10..0x17 on 8 consecutive cycles.
3. Same data, m_ready=0 -> exactly 3 fifo_rd_en pulses, then rd_en held 0 with count=3 and m_data=0x10 stable. Then m_ready=1 -> 0x10..0x17 in order, no gaps after the first.
4. 20 words, m_ready toggling 1,0,1,0 -> output sequence exact and in order, exercising wr_idx/rd_idx wrap 2->0 at least 6 times.
5. PTR_WIDTH=3, AE_THRESH=1:
   - g_wptr_sync=4'b1101 (bin 9), b_rptr=6 -> rd_level=3, almost_empty=0 one cycle later.
   - g_wptr_sync=4'b0001 (bin 1), b_rptr=15 -> rd_level=2 (wrap).
   - wbin=b_rptr -> rd_level=0, almost_empty=1.
6. Hold 2 buffered words plus 1 in flight, then pulse rrst_n low mid-cycle -> m_valid=0 immediately. After release with fifo_empty=1, no m_valid and no stale m_data is ever presented.
